// File: rtl/pdm_frontend.sv
// PDM microphone front end: divided microphone clock with clean start/stop,
// 2-FF synchronizers on the data and VAD pins, one capture per PDM period,
// and a one-entry valid/ready output buffer with sticky overflow.
//
// Timing of the outputs (all registered):
// - running_o follows the FSM state (it is registered from the next state).
// - pdm_clk_o is decoded from the current state and counter and then
//   registered, so it trails the phase counter by one cycle. Its first
//   rising edge is the cycle after the FSM enters RUN.
module pdm_frontend #(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_PHASE = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic vad_gate_en_i,
  input  logic vad_i,
  input  logic pdm_data_i,
  output logic pdm_clk_o,
  output logic data_o,
  output logic valid_o,
  input  logic ready_i,
  output logic overflow_o,
  input  logic overflow_clr_i,
  output logic running_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_SMP  = CW'(SAMPLE_PHASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_wrap;
  logic [1:0]      pd_sync_q, vad_sync_q;
  logic            pd_s, vad_s, go;
  logic            pdm_clk_q, pdm_clk_d;
  logic            running_q, running_d;
  logic            capture;
  logic            data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  // Two-flop synchronizers for the asynchronous microphone pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pd_sync_q  <= '0;
      vad_sync_q <= '0;
    end else begin
      pd_sync_q  <= {pd_sync_q[0], pdm_data_i};
      vad_sync_q <= {vad_sync_q[0], vad_i};
    end
  end

  assign pd_s  = pd_sync_q[1];
  assign vad_s = vad_sync_q[1];
  assign go    = enable_i & (~vad_gate_en_i | vad_s);

  // FSM state and phase counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_wrap = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);

  // Next state: STOP only returns to IDLE at the end of a period, so the
  // microphone never sees a shortened clock cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (go) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_wrap;
        if (!go) state_d = STOP;
      end
      STOP: begin
        cnt_d = cnt_wrap;
        if (go)                     state_d = RUN;
        else if (cnt_q == CNT_MAX)  state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: clock level, running flag and capture strobe.
  always_comb begin
    pdm_clk_d = (state_q != IDLE) && (cnt_q < CNT_HALF);
    running_d = (state_d != IDLE);
    capture   = (state_q != IDLE) && (cnt_q == CNT_SMP);
  end

  // Registered clock and running outputs keep pdm_clk_o glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pdm_clk_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pdm_clk_q <= pdm_clk_d;
      running_q <= running_d;
    end
  end

  // One-entry buffer: a capture lands if the slot is free or being popped
  // this cycle; otherwise the new bit is dropped and overflow is flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q & ~overflow_clr_i;
    if (capture) begin
      if (!valid_q || ready_i) begin
        data_d  = pd_s;
        valid_d = 1'b1;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output buffer and sticky overflow register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pdm_clk_o  = pdm_clk_q;
  assign running_o  = running_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pdm_frontend.sv
// Self-checking bench for pdm_frontend with CLK_DIV=8. Two instances share
// all inputs: dut (SAMPLE_PHASE=7) and dut3 (SAMPLE_PHASE=3). Inputs are
// driven 1 time unit after the rising edge and outputs sampled at the same
// point (all DUT outputs are registered). Cycle index k counts from the
// first cycle after enable_i is raised; in RUN, cnt = k % 8.
module tb_pdm_frontend;

  logic clk_i = 1'b0;
  logic rst_i, enable_i, vad_gate_en_i, vad_i, pdm_data_i, ready_i, overflow_clr_i;
  logic pdm_clk_o, data_o, valid_o, overflow_o, running_o;
  logic o3_pdm_clk, o3_data, o3_valid, o3_overflow, o3_running;

  int checks = 0;
  int errors = 0;

  logic q7[$];
  logic q3[$];
  logic mon7_en = 1'b0;
  logic mon3_en = 1'b0;

  always #5 clk_i = ~clk_i;

  pdm_frontend #(.CLK_DIV(8), .SAMPLE_PHASE(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .vad_gate_en_i(vad_gate_en_i),
    .vad_i(vad_i), .pdm_data_i(pdm_data_i), .pdm_clk_o(pdm_clk_o), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o),
    .overflow_clr_i(overflow_clr_i), .running_o(running_o)
  );

  pdm_frontend #(.CLK_DIV(8), .SAMPLE_PHASE(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .vad_gate_en_i(vad_gate_en_i),
    .vad_i(vad_i), .pdm_data_i(pdm_data_i), .pdm_clk_o(o3_pdm_clk), .data_o(o3_data),
    .valid_o(o3_valid), .ready_i(ready_i), .overflow_o(o3_overflow),
    .overflow_clr_i(overflow_clr_i), .running_o(o3_running)
  );

  // Scoreboard consumers: every handshake pops one expected bit.
  always @(negedge clk_i) begin
    if (mon7_en && valid_o && ready_i) begin
      checks++;
      if (q7.size() == 0) begin
        errors++;
        $display("FAIL sb7_extra got data_o=%0b required no transfer", data_o);
      end else begin
        logic e;
        e = q7.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL sb7_data got %0b required %0b", data_o, e);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (mon3_en && o3_valid && ready_i) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL sb3_extra got data_o=%0b required no transfer", o3_data);
      end else begin
        logic e;
        e = q3.pop_front();
        if (o3_data !== e) begin
          errors++;
          $display("FAIL sb3_data got %0b required %0b", o3_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; vad_gate_en_i = 1'b0; vad_i = 1'b0;
    pdm_data_i = 1'b0; ready_i = 1'b0; overflow_clr_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1; vad_gate_en_i = 1'b0; vad_i = 1'b1;
    pdm_data_i = 1'b1; ready_i = 1'b0; overflow_clr_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pdm_clk_o, data_o, valid_o, overflow_o, running_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 00000",
               {pdm_clk_o, data_o, valid_o, overflow_o, running_o});
    end
    rst_i = 1'b0; enable_i = 1'b0;
    tick();
    checks++;
    if (running_o !== 1'b0 || pdm_clk_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got run=%0b clk=%0b required 0 0", running_o, pdm_clk_o);
    end
  endtask

  task automatic test_clock();
    logic ec, ev;
    do_reset();
    ready_i = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      ec = (k >= 1) && (((k - 1) % 8) < 4);
      ev = (k >= 8) && ((k % 8) == 0);
      checks++;
      if (pdm_clk_o !== ec) begin
        errors++;
        $display("FAIL clock_pdm_clk k=%0d got %0b required %0b", k, pdm_clk_o, ec);
      end
      checks++;
      if (valid_o !== ev) begin
        errors++;
        $display("FAIL clock_valid k=%0d got %0b required %0b", k, valid_o, ev);
      end
      checks++;
      if (running_o !== 1'b1) begin
        errors++;
        $display("FAIL clock_running k=%0d got %0b required 1", k, running_o);
      end
    end
  endtask

  // Data is the pattern bit only in the cycle two before capture and its
  // complement elsewhere, so the synchronizer latency is pinned exactly.
  task automatic test_pattern(input int sp);
    int pat[4] = '{1, 0, 1, 1};
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sp == 7) q7.push_back(pat[i][0]);
      else         q3.push_back(pat[i][0]);
    end
    if (sp == 7) mon7_en = 1'b1;
    else         mon3_en = 1'b1;
    enable_i = 1'b1;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (j < 32) begin
        if ((j % 8) == sp - 2) pdm_data_i = pat[j / 8][0];
        else                   pdm_data_i = ~pat[j / 8][0];
      end
      if (j == 26) enable_i = 1'b0;
    end
    checks++;
    if (sp == 7 && q7.size() != 0) begin
      errors++;
      $display("FAIL pattern7_left got %0d pending required 0", q7.size());
    end
    if (sp == 3 && q3.size() != 0) begin
      errors++;
      $display("FAIL pattern3_left got %0d pending required 0", q3.size());
    end
    mon7_en = 1'b0;
    mon3_en = 1'b0;
    q7.delete();
    q3.delete();
  endtask

  task automatic test_stop();
    logic ec, ev, er;
    do_reset();
    ready_i = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 31; k++) begin
      tick();
      if (k == 10) enable_i = 1'b0;
      ec = (k >= 1) && (k <= 16) && (((k - 1) % 8) < 4);
      ev = (k == 8) || (k == 16);
      er = (k <= 15);
      checks++;
      if (pdm_clk_o !== ec) begin
        errors++;
        $display("FAIL stop_pdm_clk k=%0d got %0b required %0b", k, pdm_clk_o, ec);
      end
      checks++;
      if (valid_o !== ev) begin
        errors++;
        $display("FAIL stop_valid k=%0d got %0b required %0b", k, valid_o, ev);
      end
      checks++;
      if (running_o !== er) begin
        errors++;
        $display("FAIL stop_running k=%0d got %0b required %0b", k, running_o, er);
      end
    end
  endtask

  task automatic test_vad();
    logic ec, er;
    do_reset();
    ready_i = 1'b1;
    vad_gate_en_i = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 3)  vad_i = 1'b1;
      if (k == 15) vad_i = 1'b0;
      er = (k >= 6) && (k <= 21);
      ec = (k >= 7) && (k <= 22) && (((k - 7) % 8) < 4);
      checks++;
      if (running_o !== er) begin
        errors++;
        $display("FAIL vad_running k=%0d got %0b required %0b", k, running_o, er);
      end
      checks++;
      if (pdm_clk_o !== ec) begin
        errors++;
        $display("FAIL vad_pdm_clk k=%0d got %0b required %0b", k, pdm_clk_o, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    q7.push_back(1'b1);
    q7.push_back(1'b0);
    mon7_en = 1'b1;
    pdm_data_i = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 21; k++) begin
      tick();
      pdm_data_i = (k < 8);
      if (k == 10) enable_i = 1'b0;
      if (k == 15) ready_i = 1'b1;
      if (k == 14) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold got valid=%0b data=%0b required 1 1", valid_o, data_o);
        end
      end
      if (k == 16) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== 1'b0 || overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_pushpop got valid=%0b data=%0b ovf=%0b required 1 0 0",
                   valid_o, data_o, overflow_o);
        end
      end
      if (k == 17) begin
        checks++;
        if (valid_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_drain got valid=%0b required 0", valid_o);
        end
      end
    end
    checks++;
    if (q7.size() != 0) begin
      errors++;
      $display("FAIL b2b_left got %0d pending required 0", q7.size());
    end
    mon7_en = 1'b0;
    q7.delete();
  endtask

  task automatic test_overflow();
    do_reset();
    pdm_data_i = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 37; k++) begin
      tick();
      pdm_data_i = (k < 8);
      if (k == 23) overflow_clr_i = 1'b1;
      if (k == 24) begin overflow_clr_i = 1'b0; enable_i = 1'b0; end
      if (k == 33) overflow_clr_i = 1'b1;
      if (k == 34) overflow_clr_i = 1'b0;
      if (k == 15) begin
        checks++;
        if (overflow_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_before got ovf=%0b valid=%0b data=%0b required 0 1 1",
                   overflow_o, valid_o, data_o);
        end
      end
      if (k == 16) begin
        checks++;
        if (overflow_o !== 1'b1 || data_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set got ovf=%0b data=%0b required 1 1", overflow_o, data_o);
        end
      end
      if (k == 24) begin
        checks++;
        if (overflow_o !== 1'b1 || data_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set_wins got ovf=%0b data=%0b required 1 1", overflow_o, data_o);
        end
      end
      if (k == 32) begin
        checks++;
        if (running_o !== 1'b0 || valid_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_idle_keep got run=%0b valid=%0b required 0 1", running_o, valid_o);
        end
      end
      if (k == 34) begin
        checks++;
        if (overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_clear got %0b required 0", overflow_o);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    enable_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (k == 11) begin
        checks++;
        if (pdm_clk_o !== 1'b1 || valid_o !== 1'b1) begin
          errors++;
          $display("FAIL rst_pre got clk=%0b valid=%0b required 1 1", pdm_clk_o, valid_o);
        end
        rst_i = 1'b1;
        enable_i = 1'b0;
      end
      if (k == 12) begin
        checks++;
        if ({pdm_clk_o, data_o, valid_o, overflow_o, running_o} !== 5'b0) begin
          errors++;
          $display("FAIL rst_midop got %b required 00000",
                   {pdm_clk_o, data_o, valid_o, overflow_o, running_o});
        end
        rst_i = 1'b0;
      end
      if (k > 12) begin
        checks++;
        if (pdm_clk_o !== 1'b0 || running_o !== 1'b0 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rst_after k=%0d got clk=%0b run=%0b valid=%0b required 0 0 0",
                   k, pdm_clk_o, running_o, valid_o);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clock();
    test_pattern(7);
    test_pattern(3);
    test_stop();
    test_vad();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
